vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator with a small pixel FIFO.
// An upstream scanline stage writes RGB565 words into the FIFO. Scanout pops one
// word per visible pixel. The FIFO is flushed once per frame at (h=0, v=last line),
// and a one-cycle trigger pulse follows the flush to restart the upstream stage.
module vga_scanout #(
    parameter int FIFO_AW = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_write,
    input  logic [15:0] fifo_data,
    output logic        fifo_full,
    output logic        trigger,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        underflow
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_START   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_START   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE      = VW'(1);

    localparam logic [FIFO_AW:0]   CNT_DEPTH = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

    // Raster position
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // FIFO storage and bookkeeping
    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    // Per-cycle decodes of the current raster position and FIFO state
    logic        flush_s;
    logic        visible_s;
    logic        hs_active_s;
    logic        vs_active_s;
    logic        empty_s;
    logic        accept_s;
    logic        pop_s;
    logic [15:0] head_s;

    // Full flag comes straight from the registered occupancy, so upstream sees no
    // combinational path from its own request.
    assign fifo_full = (count == CNT_DEPTH);

    // Decode raster regions and the FIFO accept/pop handshake for this cycle
    always_comb begin
        flush_s     = (h_cnt == '0) && (v_cnt == V_LAST);
        visible_s   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hs_active_s = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_active_s = (v_cnt >= VS_START) && (v_cnt < VS_END);
        empty_s     = (count == '0);
        // A full FIFO never accepts, even when a pop happens in the same cycle;
        // the flush cycle drops any request so the new frame starts clean.
        accept_s    = fifo_write && !fifo_full && !flush_s && !rst;
        pop_s       = visible_s && !empty_s;
        head_s      = mem[rd_ptr];
    end

    // Horizontal and vertical counters; reset parks the raster on the flush point
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= V_LAST;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + V_ONE;
            end
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    // FIFO pointers and occupancy; flush and reset both discard the contents
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO data array write port (contents need no reset; occupancy guards reads)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem[wr_ptr] <= fifo_data;
        end
    end

    // Registered video outputs, all one cycle behind the raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            trigger   <= 1'b0;
            red       <= 5'd0;
            green     <= 6'd0;
            blue      <= 5'd0;
            underflow <= 1'b0;
        end else begin
            de      <= visible_s;
            hsync   <= !hs_active_s;
            vsync   <= !vs_active_s;
            trigger <= flush_s;
            if (pop_s) begin
                red   <= head_s[15:11];
                green <= head_s[10:5];
                blue  <= head_s[4:0];
            end else begin
                red   <= 5'd0;
                green <= 6'd0;
                blue  <= 5'd0;
            end
            if (visible_s && empty_s) begin
                underflow <= 1'b1;
            end else begin
                underflow <= underflow;
            end
        end
    end

endmodule
